// File: rtl/hp_mul_sched.sv
// Round-robin scheduler in front of an external combinational binary16 multiplier.
// Accepts one request at a time from two requesters and returns the captured result with a fixed latency.
module hp_mul_sched #(
    parameter int unsigned NUM_ROUND_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0][15:0]              req_a,
    input  logic [1:0][15:0]              req_b,
    output logic [15:0]                   mul_a_src,
    output logic [15:0]                   mul_b_src,
    output logic [5:0]                    mul_a_flags,
    output logic [5:0]                    mul_b_flags,
    input  logic [15:0]                   mul_result,
    input  logic [10+NUM_ROUND_BITS-1:0]  mul_round_mant,
    input  logic [5:0]                    mul_class,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   out_result,
    output logic [10+NUM_ROUND_BITS-1:0]  out_round_mant,
    output logic [5:0]                    out_class,
    output logic                          out_tag,
    output logic [15:0]                   op_count
);

    localparam int unsigned RW = 10 + NUM_ROUND_BITS;

    // Class flag encodings, bit order {zero,inf,subN,Norm,QNan,SNan}
    localparam logic [5:0] CLS_ZERO = 6'b100000;
    localparam logic [5:0] CLS_INF  = 6'b010000;
    localparam logic [5:0] CLS_SUBN = 6'b001000;
    localparam logic [5:0] CLS_NORM = 6'b000100;
    localparam logic [5:0] CLS_QNAN = 6'b000010;
    localparam logic [5:0] CLS_SNAN = 6'b000001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            grant_idx;
    logic            accept;
    logic            complete;
    logic            last_grant;
    logic [15:0]     a_q;
    logic [15:0]     b_q;
    logic [15:0]     op_count_q;

    function automatic logic [5:0] decode_class(input logic [15:0] x);
        logic [4:0] e;
        logic [9:0] m;
        e = x[14:10];
        m = x[9:0];
        if (e == 5'd0) begin
            return (m == 10'd0) ? CLS_ZERO : CLS_SUBN;
        end else if (e == 5'd31) begin
            if (m == 10'd0)  return CLS_INF;
            else if (m[9])   return CLS_QNAN;
            else             return CLS_SNAN;
        end
        return CLS_NORM;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration and handshake decode; the requester not granted last wins a tie
    always_comb begin
        req_ready = 2'b00;
        accept    = 1'b0;
        complete  = 1'b0;
        grant_idx = 1'b0;
        if (req_valid == 2'b11) grant_idx = ~last_grant;
        else if (req_valid[1])  grant_idx = 1'b1;
        case (state)
            IDLE: begin
                req_ready = req_valid & (grant_idx ? 2'b10 : 2'b01);
                accept    = |req_valid;
            end
            RESP:    complete = out_ready;
            default: ;
        endcase
    end

    // Operand, tag and grant-pointer capture on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            out_tag    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            a_q        <= req_a[grant_idx];
            b_q        <= req_b[grant_idx];
            out_tag    <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    // Result capture, valid flag and completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_result     <= 16'h0000;
            out_round_mant <= RW'(0);
            out_class      <= 6'b000000;
            op_count_q     <= 16'h0000;
        end else begin
            if (state == CAPTURE) begin
                out_valid      <= 1'b1;
                out_result     <= mul_result;
                out_round_mant <= mul_round_mant;
                out_class      <= mul_class;
            end else if (complete) begin
                out_valid      <= 1'b0;
                op_count_q     <= op_count_q + 16'd1;
            end
        end
    end

    assign mul_a_src   = a_q;
    assign mul_b_src   = b_q;
    assign mul_a_flags = decode_class(a_q);
    assign mul_b_flags = decode_class(b_q);
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_hp_mul_sched.sv
// Directed-plus-random bench for hp_mul_sched with an external multiplier stand-in
// and a transaction-level reference model for grants, results and the op counter.
module tb_hp_mul_sched;

    localparam int unsigned NRB = 3;
    localparam int unsigned RW  = 10 + NRB;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][15:0] req_a = '0;
    logic [1:0][15:0] req_b = '0;
    logic [15:0]      mul_a_src, mul_b_src;
    logic [5:0]       mul_a_flags, mul_b_flags;
    logic [15:0]      mul_result;
    logic [RW-1:0]    mul_round_mant;
    logic [5:0]       mul_class;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_result;
    logic [RW-1:0]    out_round_mant;
    logic [5:0]       out_class;
    logic             out_tag;
    logic [15:0]      op_count;

    int          checks = 0;
    int          failures = 0;
    logic        exp_last;
    logic [15:0] exp_count;

    hp_mul_sched #(.NUM_ROUND_BITS(NRB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a_src(mul_a_src), .mul_b_src(mul_b_src),
        .mul_a_flags(mul_a_flags), .mul_b_flags(mul_b_flags),
        .mul_result(mul_result), .mul_round_mant(mul_round_mant), .mul_class(mul_class),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_round_mant(out_round_mant),
        .out_class(out_class), .out_tag(out_tag), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: 1.0*x returns x, otherwise an arbitrary mix of the operands
    function automatic logic [15:0] mul_fn(input logic [15:0] a, input logic [15:0] b);
        return (a == 16'h3C00) ? b : ((a ^ {b[7:0], b[15:8]}) + 16'd1);
    endfunction
    function automatic logic [RW-1:0] rnd_fn(input logic [15:0] a, input logic [15:0] b);
        return RW'(a + 16'(b * 16'd3));
    endfunction
    function automatic logic [5:0] cls_fn(input logic [15:0] a, input logic [15:0] b);
        return a[15:10] ^ b[5:0];
    endfunction

    always_comb begin
        mul_result     = mul_fn(mul_a_src, mul_b_src);
        mul_round_mant = rnd_fn(mul_a_src, mul_b_src);
        mul_class      = cls_fn(mul_a_src, mul_b_src);
    end

    // Expected binary16 class from exponent/mantissa values
    function automatic logic [5:0] flag_model(input logic [15:0] x);
        int e, m;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        if (e == 0 && m == 0) return 6'b100000;
        if (e == 0)           return 6'b001000;
        if (e == 31 && m == 0) return 6'b010000;
        if (e == 31 && m >= 512) return 6'b000010;
        if (e == 31)          return 6'b000001;
        return 6'b000100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req_a[0] = 16'($urandom);
        req_a[1] = 16'($urandom);
        req_b[0] = 16'($urandom);
        req_b[1] = 16'($urandom);
    endtask

    // One complete operation; entered and left during the low clock phase while idle
    task automatic run_op(input logic [1:0] mask, input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1,
                          input int stall, input logic drop);
        logic        g;
        logic [15:0] ea, eb;
        g  = (mask == 2'b11) ? ~exp_last : mask[1];
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        req_valid = mask;
        req_a[0] = a0; req_b[0] = b0; req_a[1] = a1; req_b[1] = b1;
        #1;
        chk("grant", 32'(req_ready), 32'(g ? 2'b10 : 2'b01));
        @(posedge clk);
        exp_last = g;
        #1;
        if (drop) req_valid = 2'($urandom);
        scramble();
        out_ready = 1'($urandom);
        @(negedge clk);
        chk("a_src", 32'(mul_a_src), 32'(ea));
        chk("b_src", 32'(mul_b_src), 32'(eb));
        chk("a_flags", 32'(mul_a_flags), 32'(flag_model(ea)));
        chk("b_flags", 32'(mul_b_flags), 32'(flag_model(eb)));
        chk("ready_issue", 32'(req_ready), 32'd0);
        chk("valid_issue", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'($urandom);
        scramble();
        @(negedge clk);
        chk("valid_capture", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_ready = (stall == 0);
        @(negedge clk);
        chk("valid_resp", 32'(out_valid), 32'd1);
        chk("result", 32'(out_result), 32'(mul_fn(ea, eb)));
        chk("round", 32'(out_round_mant), 32'(rnd_fn(ea, eb)));
        chk("class", 32'(out_class), 32'(cls_fn(ea, eb)));
        chk("tag", 32'(out_tag), 32'(g));
        chk("count_resp", 32'(op_count), 32'(exp_count));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            scramble();
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", 32'(out_result), 32'(mul_fn(ea, eb)));
            chk("stall_tag", 32'(out_tag), 32'(g));
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_count", 32'(op_count), 32'(exp_count));
        end
        out_ready = 1'b1;
        @(posedge clk);
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        chk("valid_done", 32'(out_valid), 32'd0);
        chk("count_done", 32'(op_count), 32'(exp_count));
        req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] specials [6];
        specials = '{16'h0000, 16'h0001, 16'h7C00, 16'h7E00, 16'h7C01, 16'h3C00};

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_a_src", 32'(mul_a_src), 32'd0);
        chk("rst_a_flags", 32'(mul_a_flags), 32'(6'b100000));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_last  = 1'b1;
        exp_count = 16'h0000;

        // Single 1.0 * 2.0 operation from requester 0
        run_op(2'b01, 16'h3C00, 16'h4000, 16'h0000, 16'h0000, 0, 1'b0);
        chk("single_result", 32'(out_result), 32'h4000);
        chk("single_count", 32'(op_count), 32'd1);

        // Contention: alternating grants
        for (int i = 0; i < 4; i++)
            run_op(2'b11, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0);

        // Backpressure
        run_op(2'b01, 16'h4200, 16'h3800, 16'h0000, 16'h0000, 5, 1'b0);

        // Flag decode table
        for (int i = 0; i < 6; i++)
            run_op(2'b01, specials[i], specials[(i + 3) % 6], 16'h0000, 16'h0000, 0, 1'b1);

        // Random traffic
        for (int i = 0; i < 20; i++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            run_op(m, 16'($urandom), specials[$urandom_range(0, 5)], 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Counter wrap
        force dut.op_count_q = 16'hFFFF;
        #1 release dut.op_count_q;
        exp_count = 16'hFFFF;
        run_op(2'b10, 16'h3C00, 16'h1234, 16'h3C00, 16'h5678, 0, 1'b0);
        chk("wrap_count", 32'(op_count), 32'd0);

        // Reset during CAPTURE discards the operation
        req_valid = 2'b10;
        req_a[1] = 16'h3C00; req_b[1] = 16'h4400;
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk("mid_rst_tag", 32'(out_tag), 32'd0);
        chk("mid_rst_a_src", 32'(mul_a_src), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_last  = 1'b1;
        exp_count = 16'h0000;
        run_op(2'b11, 16'h3C00, 16'h4000, 16'h3C00, 16'h4400, 0, 1'b0);
        chk("post_rst_tag", 32'(out_tag), 32'd0);
        run_op(2'b11, 16'h3C00, 16'h4000, 16'h3C00, 16'h4400, 0, 1'b0);
        chk("post_rst_tag2", 32'(out_tag), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hp_mul_sched.md
HP_MUL_SCHED -- requirements
Module: hp_mul_sched

Interface
REQ-001 SHALL have parameter NUM_ROUND_BITS, default 3, round-bit count of the attached multiplier.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted when valid&ready on a rising edge.
- req_a, req_b  in  2x16  operands per requester, binary16.
- mul_a_src, mul_b_src  out  16  operands to the external combinational multiplier.
- mul_a_flags, mul_b_flags  out  6  class flags {zero,inf,subN,Norm,QNan,SNan}.
- mul_result  in  16  multiplier result.
- mul_round_mant  in  10+NUM_ROUND_BITS  multiplier rounding mantissa.
- mul_class  in  6  multiplier result class, same bit order.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_result  out  16; out_round_mant  out  10+NUM_ROUND_BITS; out_class  out  6; out_tag  out  1 (requester id).
- op_count  out  16  completed-operation counter.

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
REQ-004 In IDLE, req_ready SHALL be asserted for exactly the granted requester, and only if its req_valid=1; in all other states req_ready=0.
REQ-005 Arbitration SHALL be round-robin: if both valid, grant the requester not granted most recently; if one valid, grant it. After reset, requester 0 has priority.
REQ-006 On acceptance, operands and tag SHALL be registered, and the FSM SHALL go to ISSUE; with no valid request, it SHALL stay in IDLE.
REQ-007 mul_a_src/mul_b_src SHALL be driven only from the operand registers, never directly from req_a/req_b.
REQ-008 Flags SHALL be decoded from the registered operands: exp=0&man=0 zero; exp=0&man!=0 subN; exp=31&man=0 inf; exp=31&man[9]=1 QNan; exp=31&man[9]=0&man!=0 SNan; else Norm. Exactly one flag SHALL be set per operand.
REQ-009 ISSUE SHALL last one cycle, so the operands are stable for a full cycle before capture; the FSM then goes to CAPTURE.
REQ-010 On the CAPTURE edge, mul_result, mul_round_mant and mul_class SHALL be registered into the out_* registers, out_valid SHALL be set, and the FSM SHALL go to RESP.
REQ-011 Latency SHALL be fixed: acceptance at edge N, then out_valid=1 after edge N+2.
REQ-012 In RESP, out_* SHALL hold stable while out_valid=1&out_ready=0.
REQ-013 In RESP with out_ready=1, on the next edge out_valid SHALL go to 0, op_count SHALL increment by 1 and the FSM SHALL go to IDLE. op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-014 out_ready SHALL be ignored outside RESP.
REQ-015 Throughput SHALL be at most one operation per 4 cycles. The operation is non-pipelined, and a new request SHALL never be accepted while an operation is outstanding.
REQ-016 Deasserting req_valid after acceptance SHALL NOT affect the in-flight operation.
REQ-017 The last-grant pointer SHALL update only on acceptance.

Reset
REQ-018 While rst_n=0, regardless of clk, the block SHALL immediately force: FSM=IDLE, req_ready=0, out_valid=0, out_result=0, out_round_mant=0, out_class=0, out_tag=0, op_count=0, operand registers=0 (flags then decode to zero), last-grant=1 so requester 0 wins first.
REQ-019 Reset asserted mid-operation SHALL discard the operation: no out_valid and no op_count increment.
REQ-020 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-021 Single op: req0 a=0x3C00 (1.0), b=0x4000 (2.0), mul model returns 0x4000 -> out_valid 2 cycles after acceptance, out_result=0x4000, out_tag=0, op_count 0->1 after the handshake.
REQ-022 Contention: both valid continuously with out_ready=1 -> grants alternate 0,1,0,1 and out_tag follows the same sequence, one result per 4 cycles.
REQ-023 Backpressure: out_ready=0 for 5 cycles in RESP -> out_* stable and req_ready=0 throughout; completion on the first cycle with out_ready=1.
REQ-024 Flag decode: operands 0x0000, 0x0001, 0x7C00, 0x7E00, 0x7C01, 0x3C00 -> mul_a_flags = zero, subN, inf, QNan, SNan, Norm respectively.
REQ-025 Reset mid-op: rst_n low during CAPTURE -> outputs reset immediately, no out_valid, op_count=0, requester 0 granted first after release.
REQ-026 Wrap: preload via 65535 ops (or force) op_count=0xFFFF, complete one op -> op_count=0x0000.
